// File: rtl/vote3_key_capture.sv
// Three-voter key capture: synchronizes and debounces four push buttons and runs the voting session FSM.
// Define VOTE3_TIMEOUT_EN to add the window counter; without it a session closes only on a START press.
module vote3_key_capture #(
  parameter int unsigned DEBOUNCE_CNT = 1000000,
  parameter int unsigned WINDOW_CNT   = 250000000
) (
  input  logic       CLK_50M,
  input  logic       RST,
  input  logic       KEY_A,
  input  logic       KEY_B,
  input  logic       KEY_C,
  input  logic       KEY_START,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       VALID,
  output logic       OPEN,
  output logic [1:0] o_dbg_state
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CNT - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_OPEN = 2'd1, S_CLOSED = 2'd2} state_t;

  // Key vector order: {START, C, B, A}; all keys are active-low.
  logic [3:0]    w_raw;
  logic [3:0]    r_sync1;
  logic [3:0]    r_sync2;
  logic [3:0]    r_level;
  logic [3:0]    r_press;
  logic [DW-1:0] r_db_cnt [4];

  state_t r_state;
  state_t w_state_nxt;
  logic   w_a_nxt;
  logic   w_b_nxt;
  logic   w_c_nxt;
  logic   w_load;
  logic   w_expire;
  logic   w_press_start;

  assign w_raw         = {KEY_START, KEY_C, KEY_B, KEY_A};
  assign w_press_start = r_press[3];
  assign o_dbg_state   = r_state;

  // Press pulses are registered on the same edge that the debounced level falls.
  always_ff @(posedge CLK_50M) begin
    if (RST) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
      r_level <= '1;
      r_press <= '0;
      for (int i = 0; i < 4; i++) r_db_cnt[i] <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      r_press <= '0;
      for (int i = 0; i < 4; i++) begin
        if (r_sync2[i] == r_level[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_LAST) begin
          r_level[i]  <= r_sync2[i];
          r_db_cnt[i] <= '0;
          r_press[i]  <= ~r_sync2[i];
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + DW'(1);
        end
      end
    end
  end

`ifdef VOTE3_TIMEOUT_EN
  localparam int unsigned WW = (WINDOW_CNT > 1) ? $clog2(WINDOW_CNT) : 1;
  localparam logic [WW-1:0] WIN_LOAD = WW'(WINDOW_CNT - 1);
  logic [WW-1:0] r_win;

  assign w_expire = (r_win == '0);

  always_ff @(posedge CLK_50M) begin
    if (RST) begin
      r_win <= '0;
    end else if (w_load) begin
      r_win <= WIN_LOAD;
    end else if ((r_state == S_OPEN) && (r_win != '0)) begin
      r_win <= r_win - WW'(1);
    end
  end
`else
  assign w_expire = 1'b0;
`endif

  // Votes are OR-ed in on the closing edge too, so a coincident press still counts.
  always_comb begin
    w_state_nxt = r_state;
    w_a_nxt     = A;
    w_b_nxt     = B;
    w_c_nxt     = C;
    w_load      = 1'b0;
    unique case (r_state)
      S_IDLE, S_CLOSED: begin
        if (w_press_start) begin
          w_state_nxt = S_OPEN;
          w_a_nxt     = 1'b0;
          w_b_nxt     = 1'b0;
          w_c_nxt     = 1'b0;
          w_load      = 1'b1;
        end
      end
      S_OPEN: begin
        w_a_nxt = A | r_press[0];
        w_b_nxt = B | r_press[1];
        w_c_nxt = C | r_press[2];
        if (w_press_start || w_expire) w_state_nxt = S_CLOSED;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK_50M) begin
    if (RST) begin
      r_state <= S_IDLE;
      A       <= 1'b0;
      B       <= 1'b0;
      C       <= 1'b0;
      VALID   <= 1'b0;
      OPEN    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      A       <= w_a_nxt;
      B       <= w_b_nxt;
      C       <= w_c_nxt;
      VALID   <= (w_state_nxt == S_CLOSED);
      OPEN    <= (w_state_nxt == S_OPEN);
    end
  end

endmodule

// File: tb/tb_vote3_key_capture.sv
// Bench for vote3_key_capture: directed session scenarios plus random key activity,
// every cycle compared against a behavioural model of the voting rules.
module tb_vote3_key_capture;

  localparam int DB  = 4;
  localparam int WIN = 50;
`ifdef VOTE3_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  logic key_a, key_b, key_c, key_start;
  logic a, b, c, valid, open_o;
  logic [1:0] dbg_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  vote3_key_capture #(.DEBOUNCE_CNT(DB), .WINDOW_CNT(WIN)) dut (
    .CLK_50M(clk), .RST(rst),
    .KEY_A(key_a), .KEY_B(key_b), .KEY_C(key_c), .KEY_START(key_start),
    .A(a), .B(b), .C(c), .VALID(valid), .OPEN(open_o),
    .o_dbg_state(dbg_state)
  );

  int vectors = 0;
  int miscompares = 0;

  // ---------------- reference model ----------------
  // Sessions: 0 idle, 1 open, 2 closed. Keys low = pressed.
  logic [3:0] raw_q [$];
  bit         samp_q [4][$];
  logic [3:0] m_level;
  logic [3:0] m_press_prev;
  int         m_sess;
  int         m_age;
  logic       m_a, m_b, m_c, m_valid, m_open;

  task automatic m_open_fresh();
    m_sess = 1; m_age = 0;
    m_a = 1'b0; m_b = 1'b0; m_c = 1'b0;
  endtask

  task automatic model_step();
    logic [3:0] raw, s, p, pnow;
    bit flip;
    raw = {key_start, key_c, key_b, key_a};
    if (rst) begin
      raw_q.delete(); raw_q.push_back(4'hF); raw_q.push_back(4'hF);
      for (int i = 0; i < 4; i++) samp_q[i].delete();
      m_level = 4'hF; m_press_prev = 4'h0; m_sess = 0; m_age = 0;
      m_a = 1'b0; m_b = 1'b0; m_c = 1'b0; m_valid = 1'b0; m_open = 1'b0;
      return;
    end
    p = m_press_prev;
    case (m_sess)
      1: begin
        m_a = m_a | p[0]; m_b = m_b | p[1]; m_c = m_c | p[2];
        m_age++;
        if (p[3] || (TIMEOUT_EN && m_age >= WIN)) m_sess = 2;
      end
      default: if (p[3]) m_open_fresh();
    endcase
    m_open  = (m_sess == 1);
    m_valid = (m_sess == 2);
    // A level is accepted once the last DB synchronized samples since the previous change all disagree with it.
    raw_q.push_back(raw);
    s = raw_q.pop_front();
    pnow = 4'h0;
    for (int i = 0; i < 4; i++) begin
      samp_q[i].push_back(s[i]);
      if (samp_q[i].size() > DB) void'(samp_q[i].pop_front());
      flip = (samp_q[i].size() == DB);
      foreach (samp_q[i][j]) if (samp_q[i][j] == m_level[i]) flip = 1'b0;
      if (flip) begin
        pnow[i]    = m_level[i];
        m_level[i] = ~m_level[i];
        samp_q[i].delete();
      end
    end
    m_press_prev = pnow;
  endtask

  // ---------------- checkers ----------------
  task automatic chk(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("A", a, m_a);
    chk("B", b, m_b);
    chk("C", c, m_c);
    chk("VALID", valid, m_valid);
    chk("OPEN", open_o, m_open);
    chk("dbg_state_legal", (dbg_state != 2'b11), 1'b1);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_key(input int idx, input logic v);
    case (idx)
      0: key_a = v;
      1: key_b = v;
      2: key_c = v;
      default: key_start = v;
    endcase
  endtask

  task automatic hold_key(input int idx, input int n_low, input int n_high);
    set_key(idx, 1'b0); ticks(n_low);
    set_key(idx, 1'b1); ticks(n_high);
  endtask

  // Presses START until the window opens, then releases it; n = cycles to OPEN.
  task automatic start_open(output int n);
    key_start = 1'b0;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      tick(); n++;
      if (open_o) break;
    end
    key_start = 1'b1;
    chk("open_seen", open_o, 1'b1);
  endtask

  task automatic wait_valid(input int budget, output int n);
    n = 0;
    for (int i = 0; i < budget; i++) begin
      if (valid) break;
      tick(); n++;
    end
    chk("valid_seen", valid, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    rst = 1'b1; key_a = 1'b1; key_b = 1'b1; key_c = 1'b1; key_start = 1'b1;
    ticks(3);
    rst = 1'b0;
    chk("rst_A", a, 1'b0); chk("rst_VALID", valid, 1'b0); chk("rst_OPEN", open_o, 1'b0);
    ticks(4);

    // First session opens 7 cycles after START goes low (2 sync + 4 debounce + 1 FSM).
    start_open(n);
    chk_int("start_latency", n, 7);
    chk("open_A", a, 1'b0); chk("open_B", b, 1'b0); chk("open_C", c, 1'b0);
    chk("open_VALID", valid, 1'b0);
    ticks(8);

    // A and C vote, START closes.
    key_a = 1'b0; key_c = 1'b0; ticks(10);
    key_a = 1'b1; key_c = 1'b1; ticks(8);
    hold_key(3, 10, 8);
    chk("ballot_A", a, 1'b1); chk("ballot_B", b, 1'b0); chk("ballot_C", c, 1'b1);
    chk("ballot_VALID", valid, 1'b1); chk("ballot_OPEN", open_o, 1'b0);
    chk("voter_L", (a & b) | (a & c) | (b & c), 1'b1);

    // Fresh session, bouncing B never registers, then a steady B press does.
    start_open(n);
    chk("reopen_A", a, 1'b0); chk("reopen_C", c, 1'b0);
    ticks(8);
    for (int i = 0; i < 5; i++) begin
      key_b = 1'b0; ticks(2);
      key_b = 1'b1; ticks(2);
    end
    chk("bounce_B", b, 1'b0);
    key_b = 1'b0; n = 0;
    for (int i = 0; i < 15; i++) begin
      tick(); n++;
      if (b) break;
    end
    chk("steady_B", b, 1'b1);
    chk_int("steady_B_latency", n, 7);
    key_b = 1'b1; ticks(8);

    // Window expiry.
`ifdef VOTE3_TIMEOUT_EN
    wait_valid(80, n);
`else
    hold_key(3, 10, 8);
`endif
    chk("closed_VALID", valid, 1'b1);
    ticks(4);
    start_open(n);
`ifdef VOTE3_TIMEOUT_EN
    wait_valid(100, n);
    chk_int("window_len", n, WIN);
    chk("expire_A", a, 1'b0); chk("expire_B", b, 1'b0); chk("expire_C", c, 1'b0);
    ticks(8);
    // KEY_A pulse lands on the expiry edge: low before edge e+44 -> press consumed at e+50.
    start_open(n);
    ticks(43);
    key_a = 1'b0; ticks(10);
    key_a = 1'b1; ticks(10);
    chk("coincide_VALID", valid, 1'b1);
    chk("coincide_A", a, 1'b1);
`else
    ticks(210);
    chk("no_timeout_OPEN", open_o, 1'b1);
    hold_key(3, 10, 8);
`endif

    // Votes ignored while closed.
    ticks(5);
    hold_key(1, 10, 8);
    chk("closed_B", b, 1'b0);
    chk("closed_A", a, TIMEOUT_EN);
    chk("closed_VALID2", valid, 1'b1);

    // Reset mid-window discards the B vote.
    start_open(n);
    ticks(6);
    hold_key(1, 8, 2);
    chk("pre_rst_B", b, 1'b1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("mid_rst_B", b, 1'b0); chk("mid_rst_OPEN", open_o, 1'b0);
    chk("mid_rst_VALID", valid, 1'b0);
    ticks(8);

    // Key held low across reset release produces no vote.
    key_a = 1'b0;
    rst = 1'b1; ticks(2); rst = 1'b0;
    ticks(12);
    chk("held_A", a, 1'b0); chk("held_OPEN", open_o, 1'b0);
    key_a = 1'b1; ticks(8);

    // Random key activity with occasional resets.
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if ($urandom_range(0, 3) == 0) key_a = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) key_b = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) key_c = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 29) == 0) key_start = ~key_start;
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
